// File: rtl/seg7_frame_decoder.sv
// Watches a multiplexed 8-digit seven-segment display. It recovers the Celsius and
// Fahrenheit readings from a frame shaped like "C°dd F°dd" (slot 0 .. slot 7).
module seg7_frame_decoder #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic [7:0] an,
  input  logic [6:0] seg,
  output logic [7:0] c_data,
  output logic [7:0] f_data,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam logic [15:0] SETTLE     = 16'(SETTLE_CYCLES);
  localparam logic [15:0] SAMPLE_PRE = 16'(SETTLE_CYCLES - 2);

  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_DEG = 7'b0011100;
  localparam logic [6:0] SEG_F   = 7'b0111000;

  logic [7:0]  r_an;
  logic [6:0]  r_seg;
  logic [7:0]  r_an_d;
  logic [6:0]  r_seg_d;
  logic [15:0] r_cnt;
  logic [7:0]  r_mask;
  logic        r_err;
  logic [3:0]  r_c_ones;
  logic [3:0]  r_c_tens;
  logic [3:0]  r_f_ones;
  logic [3:0]  r_f_tens;

  logic [2:0]  w_slot;
  logic [3:0]  w_zeros;
  logic        w_idle;
  logic        w_stable;
  logic        w_sample;
  logic        w_digit_ok;
  logic [3:0]  w_digit;
  logic [3:0]  w_store;
  logic        w_bad;
  logic        w_complete;
  logic [7:0]  w_mask_next;
  logic        w_err_next;
  logic [7:0]  w_c_val;
  logic [7:0]  w_f_val;

  // The slot is valid only when exactly one anode line is low.
  always_comb begin
    w_slot  = 3'd0;
    w_zeros = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (!r_an[i]) begin
        w_zeros = w_zeros + 4'd1;
        w_slot  = 3'(i);
      end
    end
    w_idle = (w_zeros != 4'd1);
  end

  assign w_stable = !w_idle && (r_an == r_an_d) && (r_seg == r_seg_d);
  // Fire on the edge that moves the counter onto SETTLE-1, so each dwell samples once.
  assign w_sample = w_stable && (r_cnt == SAMPLE_PRE);

  always_comb begin
    w_digit_ok = 1'b1;
    w_digit    = 4'd0;
    case (r_seg)
      7'b0000001: w_digit = 4'd0;
      7'b1001111: w_digit = 4'd1;
      7'b0010010: w_digit = 4'd2;
      7'b0000110: w_digit = 4'd3;
      7'b1001100: w_digit = 4'd4;
      7'b0100100: w_digit = 4'd5;
      7'b0100000: w_digit = 4'd6;
      7'b0001111: w_digit = 4'd7;
      7'b0000000: w_digit = 4'd8;
      7'b0000100: w_digit = 4'd9;
      default:    w_digit_ok = 1'b0;
    endcase
    w_store = w_digit_ok ? w_digit : 4'd0;
  end

  always_comb begin
    w_bad = 1'b0;
    case (w_slot)
      3'd0:       w_bad = (r_seg != SEG_C);
      3'd1, 3'd5: w_bad = (r_seg != SEG_DEG);
      3'd4:       w_bad = (r_seg != SEG_F);
      default:    w_bad = !w_digit_ok;
    endcase
  end

  // On completion the mask and error restart, but a sample landing in the same cycle
  // already belongs to the next frame.
  assign w_complete  = (r_mask == 8'hFF);
  assign w_mask_next = (w_complete ? 8'h00 : r_mask) |
                       (w_sample ? 8'(8'd1 << w_slot) : 8'h00);
  assign w_err_next  = (w_complete ? 1'b0 : r_err) | (w_sample && w_bad);

  assign w_c_val = 8'({4'd0, r_c_tens} << 3) + 8'({4'd0, r_c_tens} << 1) + {4'd0, r_c_ones};
  assign w_f_val = 8'({4'd0, r_f_tens} << 3) + 8'({4'd0, r_f_tens} << 1) + {4'd0, r_f_ones};

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      r_an        <= 8'd0;
      r_seg       <= 7'd0;
      r_an_d      <= 8'd0;
      r_seg_d     <= 7'd0;
      r_cnt       <= 16'd0;
      r_mask      <= 8'd0;
      r_err       <= 1'b0;
      r_c_ones    <= 4'd0;
      r_c_tens    <= 4'd0;
      r_f_ones    <= 4'd0;
      r_f_tens    <= 4'd0;
      c_data      <= 8'd0;
      f_data      <= 8'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_an    <= an;
      r_seg   <= seg;
      r_an_d  <= r_an;
      r_seg_d <= r_seg;

      if (!w_stable) begin
        r_cnt <= 16'd0;
      end else if (r_cnt < SETTLE) begin
        r_cnt <= r_cnt + 16'd1;
      end

      r_mask <= w_mask_next;
      r_err  <= w_err_next;

      if (w_sample) begin
        case (w_slot)
          3'd2:    r_c_ones <= w_store;
          3'd3:    r_c_tens <= w_store;
          3'd6:    r_f_ones <= w_store;
          3'd7:    r_f_tens <= w_store;
          default: ;
        endcase
      end

      frame_valid <= w_complete && !r_err;
      frame_err   <= w_complete && r_err;
      if (w_complete && !r_err) begin
        c_data <= w_c_val;
        f_data <= w_f_val;
      end
    end
  end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder: it drives display frames and checks the decoded
// readings and pulse counts against hand-computed values.
module tb_seg7_frame_decoder;

  logic       clk_100MHz = 1'b0;
  logic       rst_n;
  logic [7:0] an;
  logic [6:0] seg;
  logic [7:0] c_data;
  logic [7:0] f_data;
  logic       frame_valid;
  logic       frame_err;

  int n_cmp  = 0;
  int n_fail = 0;

  int         n_valid   = 0;
  int         n_err     = 0;
  int         n_overlap = 0;
  logic [7:0] last_c    = 8'd0;
  logic [7:0] last_f    = 8'd0;
  logic       prev_pulse = 1'b0;

  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_DEG = 7'b0011100;
  localparam logic [6:0] SEG_F   = 7'b0111000;

  seg7_frame_decoder #(.SETTLE_CYCLES(16)) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .an         (an),
    .seg        (seg),
    .c_data     (c_data),
    .f_data     (f_data),
    .frame_valid(frame_valid),
    .frame_err  (frame_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk_100MHz) begin
    if (frame_valid) begin
      n_valid = n_valid + 1;
      last_c  = c_data;
      last_f  = f_data;
    end
    if (frame_err) n_err = n_err + 1;
    if (frame_valid && frame_err) n_overlap = n_overlap + 1;
    if ((frame_valid || frame_err) && prev_pulse) n_overlap = n_overlap + 1;
    prev_pulse = frame_valid || frame_err;
  end

  function automatic logic [6:0] seg_digit(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [6:0] frame_seg(input int slot, input int c, input int f);
    case (slot)
      0: return SEG_C;
      1, 5: return SEG_DEG;
      2: return seg_digit(c % 10);
      3: return seg_digit(c / 10);
      4: return SEG_F;
      6: return seg_digit(f % 10);
      default: return seg_digit(f / 10);
    endcase
  endfunction

  task automatic drive_slot(input int slot, input logic [6:0] s, input int dwell);
    @(negedge clk_100MHz);
    an  = ~(8'd1 << slot);
    seg = s;
    repeat (dwell) @(posedge clk_100MHz);
  endtask

  task automatic drive_an(input logic [7:0] a, input int cycles);
    @(negedge clk_100MHz);
    an = a;
    repeat (cycles) @(posedge clk_100MHz);
  endtask

  task automatic send_frame(input int c, input int f, input int dwell);
    for (int s = 0; s < 8; s++) drive_slot(s, frame_seg(s, c, f), dwell);
    drive_an(8'hFF, 6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    an    = 8'hFF;
    seg   = 7'h7F;
    repeat (3) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    n_cmp += 4;
    if (c_data !== 8'd0)    begin n_fail++; $display("FAIL reset_c_data got %0d want 0", c_data); end
    if (f_data !== 8'd0)    begin n_fail++; $display("FAIL reset_f_data got %0d want 0", f_data); end
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", frame_valid); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", frame_err); end
    rst_n = 1'b1;
  endtask

  task automatic check_frame(input string name, input int bv, input int be,
                             input int want_v, input int want_e, input int c, input int f);
    n_cmp += 2;
    if (n_valid - bv !== want_v) begin n_fail++; $display("FAIL %s_valid_count got %0d want %0d", name, n_valid - bv, want_v); end
    if (n_err - be !== want_e)   begin n_fail++; $display("FAIL %s_err_count got %0d want %0d", name, n_err - be, want_e); end
    if (c >= 0) begin
      n_cmp += 2;
      if (c_data !== 8'(c)) begin n_fail++; $display("FAIL %s_c_data got %0d want %0d", name, c_data, c); end
      if (f_data !== 8'(f)) begin n_fail++; $display("FAIL %s_f_data got %0d want %0d", name, f_data, f); end
    end
    if (want_v > 0) begin
      n_cmp += 2;
      if (last_c !== 8'(c)) begin n_fail++; $display("FAIL %s_pulse_c got %0d want %0d", name, last_c, c); end
      if (last_f !== 8'(f)) begin n_fail++; $display("FAIL %s_pulse_f got %0d want %0d", name, last_f, f); end
    end
  endtask

  task automatic test_basic();
    int bv = n_valid, be = n_err;
    send_frame(25, 77, 20);
    check_frame("basic", bv, be, 1, 0, 25, 77);
  endtask

  task automatic test_bad_slot();
    int bv = n_valid, be = n_err;
    for (int s = 0; s < 8; s++)
      drive_slot(s, (s == 4) ? SEG_C : frame_seg(s, 61, 42), 20);
    drive_an(8'hFF, 6);
    check_frame("bad_slot", bv, be, 0, 1, 25, 77);
  endtask

  task automatic test_dwell_boundary();
    int bv = n_valid, be = n_err;
    send_frame(11, 22, 15);
    check_frame("dwell15", bv, be, 0, 0, 25, 77);
    bv = n_valid; be = n_err;
    send_frame(11, 22, 16);
    check_frame("dwell16", bv, be, 1, 0, 11, 22);
  endtask

  task automatic test_glitch();
    int bv = n_valid, be = n_err;
    drive_slot(0, SEG_C, 20);
    drive_an(8'hFF, 3);
    drive_slot(1, SEG_DEG, 20);
    drive_an(8'hFC, 3);
    drive_slot(2, seg_digit(9), 5);
    @(negedge clk_100MHz); seg = seg_digit(8);
    @(posedge clk_100MHz);
    @(negedge clk_100MHz); seg = seg_digit(9);
    repeat (20) @(posedge clk_100MHz);
    drive_slot(3, seg_digit(0), 20);
    drive_slot(4, SEG_F, 20);
    drive_an(8'hFF, 2);
    drive_slot(5, SEG_DEG, 20);
    drive_slot(6, seg_digit(8), 20);
    drive_an(8'hFC, 4);
    drive_slot(7, seg_digit(4), 20);
    drive_an(8'hFF, 6);
    check_frame("glitch", bv, be, 1, 0, 9, 48);
  endtask

  task automatic test_reset_mid_frame();
    int bv, be;
    for (int s = 0; s < 6; s++) drive_slot(s, frame_seg(s, 12, 34), 20);
    drive_an(8'hFF, 2);
    @(negedge clk_100MHz);
    rst_n = 1'b0;
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    n_cmp += 4;
    if (c_data !== 8'd0)      begin n_fail++; $display("FAIL midreset_c_data got %0d want 0", c_data); end
    if (f_data !== 8'd0)      begin n_fail++; $display("FAIL midreset_f_data got %0d want 0", f_data); end
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", frame_valid); end
    if (frame_err !== 1'b0)   begin n_fail++; $display("FAIL midreset_err got %b want 0", frame_err); end
    rst_n = 1'b1;
    bv = n_valid; be = n_err;
    drive_slot(6, frame_seg(6, 56, 78), 20);
    drive_slot(7, frame_seg(7, 56, 78), 20);
    drive_an(8'hFF, 6);
    check_frame("after_reset_partial", bv, be, 0, 0, 0, 0);
    for (int s = 0; s < 6; s++) drive_slot(s, frame_seg(s, 56, 78), 20);
    drive_an(8'hFF, 6);
    check_frame("after_reset_full", bv, be, 1, 0, 56, 78);
  endtask

  task automatic test_reverse_resample();
    int bv = n_valid, be = n_err;
    for (int s = 7; s >= 0; s--) begin
      if (s == 2) drive_slot(2, seg_digit(3), 20);
      drive_slot(s, frame_seg(s, 34, 90), 20);
    end
    drive_an(8'hFF, 6);
    check_frame("reverse", bv, be, 1, 0, 34, 90);
  endtask

  task automatic test_back_to_back();
    int bv = n_valid, be = n_err;
    send_frame(99, 0, 17);
    send_frame(40, 95, 18);
    check_frame("back_to_back", bv, be, 2, 0, 40, 95);
    n_cmp++;
    if (n_overlap !== 0) begin n_fail++; $display("FAIL pulse_overlap got %0d want 0", n_overlap); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_slot();
    test_dwell_boundary();
    test_glitch();
    test_reset_mid_frame();
    test_reverse_resample();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_frame_decoder.md
SEG7_FRAME_DECODER -- requirements
Module: seg7_frame_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: consecutive stable cycles needed before a digit slot is sampled; legal range 2..65535.
REQ-002 clk_100MHz  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 an  input  8  anode enables, active-low; one zero bit selects slot 0..7.
REQ-005 seg  input  7  segment lines, active-low, bit6=a .. bit0=g.
REQ-006 c_data  output  8  last good Celsius value, binary 0..99.
REQ-007 f_data  output  8  last good Fahrenheit value, binary 0..99.
REQ-008 frame_valid  output  1  one-cycle pulse when c_data/f_data update.
REQ-009 frame_err  output  1  one-cycle pulse when a completed frame is rejected.

Function
REQ-010 an and seg SHALL pass through one input register stage; all later logic SHALL use only the registered copies.
REQ-011 Slot index SHALL be the position of the single zero bit in registered an; any other an value (no zero, or two or more zeros) is idle.
REQ-012 A stability counter SHALL clear to 0 whenever {an,seg} differs from the previous cycle or an is idle; otherwise it SHALL increment, saturating at SETTLE_CYCLES.
REQ-013 A slot SHALL be sampled exactly once per dwell, on the cycle the counter first reaches SETTLE_CYCLES-1.
REQ-014 Digit decode: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
REQ-015 Slot content rules: slot 0 = 0110001 (C); slots 1 and 5 = 0011100 (degree); slot 4 = 0111000 (F); slots 2/3 = C ones/tens digit; slots 6/7 = F ones/tens digit.
REQ-016 A sample not matching its slot rule SHALL set the frame error flag; a digit slot with a bad pattern stores 0.
REQ-017 Each sample SHALL set the slot's bit in an 8-bit captured mask; resampling an already-captured slot overwrites its stored digit, and the error flag stays set.
REQ-018 Slot visit order SHALL NOT matter.
REQ-019 On the cycle after the mask becomes 8'hFF, if the error flag is clear, c_data SHALL equal tens*10+ones for slots 3/2 and f_data for slots 7/6, and frame_valid SHALL pulse in that same cycle.
REQ-020 If the error flag is set at that point, frame_err SHALL pulse instead and c_data/f_data SHALL hold.
REQ-021 In the completion cycle, the mask and error flag SHALL clear. A sample taken in that same cycle SHALL count toward the new frame.
REQ-022 frame_valid and frame_err SHALL never assert together and SHALL never assert for two consecutive cycles.
REQ-023 Arithmetic SHALL use 8-bit unsigned values; the maximum result is 99, so no overflow occurs.

Reset
REQ-024 With rst_n low at a clock edge, the following SHALL clear to 0 on that edge: c_data, f_data, frame_valid, frame_err, captured mask, error flag, stability counter, stored digits and input registers.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame. After release, a full new 8-slot frame SHALL be required before frame_valid.

Verification
REQ-026 With SETTLE_CYCLES=16, drive a full frame for 25 C / 77 F, slots 0..7, 20-cycle dwell each -> one frame_valid pulse, c_data=25, f_data=77.
REQ-027 Same frame with slot 4 showing 0110001 (C instead of F) -> one frame_err pulse, no frame_valid, c_data/f_data hold their previous values.
REQ-028 Dwell of 15 cycles on every slot -> no samples taken and no pulse; then dwell 16 cycles -> exactly one frame_valid.
REQ-029 Insert an=8'hFF and an=8'hFC glitches between slots, and a one-cycle seg change inside a dwell -> the glitches are ignored, the counter restarts, and the frame decodes correctly (c_data=9, f_data=48).
REQ-030 Assert rst_n=0 for one cycle after slot 5 is sampled, then send one full frame -> all outputs read 0 after the reset edge, and exactly one frame_valid occurs with values from the new frame only.
REQ-031 Frame in order 7,6,...,0, with slot 2 repeated (value 3 then 4), for 34 C / 90 F -> one frame_valid, c_data=34, f_data=90.
